// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per cycle.
// Optional leading-zero blanking is enabled with the BIN2BCD_LZB_EN macro.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    Dec_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] BCD_out,
    output logic                sign_out,
    output logic                ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q;
    logic [WIDTH-1:0] bin_q;
    logic [BW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;
    logic             negative_q;
    logic             ovfFlag_q;

    logic             neg_d;
    logic [WIDTH-1:0] mag_d;
    logic [BW-1:0]    accAdj_d;
    logic [BW-1:0]    accShift_d;
    logic [WIDTH-1:0] binShift_d;
    logic             carry_d;
    logic [BW-1:0]    result_d;

    // Most-negative input wraps to its own bit pattern, which read unsigned is the right magnitude.
    always_comb begin
        neg_d = (SIGNED != 0) && Dec_in[WIDTH-1];
        mag_d = neg_d ? (~Dec_in + WIDTH'(1)) : Dec_in;
    end

    always_comb begin
        accAdj_d = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                accAdj_d[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        {carry_d, accShift_d, binShift_d} = {accAdj_d, bin_q, 1'b0};
    end

`ifdef BIN2BCD_LZB_EN
    // Blank zero digits above the most significant nonzero digit; digit 0 always shows.
    always_comb begin
        logic seenNz;
        result_d = acc_q;
        seenNz   = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (acc_q[4*i +: 4] != 4'd0) begin
                seenNz = 1'b1;
            end else if (!seenNz) begin
                result_d[4*i +: 4] = 4'hF;
            end
        end
    end
`else
    assign result_d = acc_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            negative_q <= 1'b0;
            ovfFlag_q  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            BCD_out    <= '0;
            sign_out   <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_q      <= mag_d;
                        acc_q      <= '0;
                        ovfFlag_q  <= 1'b0;
                        negative_q <= neg_d;
                        cnt_q      <= CW'(WIDTH);
                        busy       <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q <= accShift_d;
                    bin_q <= binShift_d;
                    if (carry_d) begin
                        ovfFlag_q <= 1'b1;
                    end
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    BCD_out  <= result_d;
                    sign_out <= negative_q;
                    ovf      <= ovfFlag_q;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: three parameterisations checked every cycle against
// an arithmetic reference, plus hand-computed literal results.
`ifdef BIN2BCD_LZB_EN
`define LZ(plain, blank) blank
`else
`define LZ(plain, blank) plain
`endif

module tb_bin_to_bcd_seq;

    localparam int W = 16;
    localparam int DIGITS_P [3] = '{5, 5, 4};
    localparam bit SIGNED_P [3] = '{1'b1, 1'b0, 1'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  startV = '0;
    logic [15:0] decV [3];
    logic [2:0]  busyV, doneV, signV, ovfV;
    logic [19:0] bcdA, bcdB;
    logic [15:0] bcdC;
    logic [19:0] bcdAct [3];
    bit          checkEn = 1'b0;

    int nVec = 0;
    int nMis = 0;

    bit          activeM [3];
    int          ageM    [3];
    logic [19:0] bcdM    [3];
    bit          signM   [3];
    bit          ovfM    [3];
    bit          doneM   [3];
    logic [19:0] pendBcd [3];
    bit          pendSign[3];
    bit          pendOvf [3];

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1)) dutA (
        .clk(clk), .rst(rst), .start(startV[0]), .Dec_in(decV[0]),
        .busy(busyV[0]), .done(doneV[0]), .BCD_out(bcdA),
        .sign_out(signV[0]), .ovf(ovfV[0]));

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) dutB (
        .clk(clk), .rst(rst), .start(startV[1]), .Dec_in(decV[1]),
        .busy(busyV[1]), .done(doneV[1]), .BCD_out(bcdB),
        .sign_out(signV[1]), .ovf(ovfV[1]));

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4), .SIGNED(0)) dutC (
        .clk(clk), .rst(rst), .start(startV[2]), .Dec_in(decV[2]),
        .busy(busyV[2]), .done(doneV[2]), .BCD_out(bcdC),
        .sign_out(signV[2]), .ovf(ovfV[2]));

    assign bcdAct[0] = bcdA;
    assign bcdAct[1] = bcdB;
    assign bcdAct[2] = {4'h0, bcdC};

    // Reference conversion from plain integer arithmetic.
    function automatic void refConv(input logic [15:0] v, input int digits, input bit sgn,
                                    output logic [19:0] bcd, output bit neg, output bit ov);
        longint mag;
        longint lim;
        neg = sgn && v[15];
        mag = neg ? (64'd65536 - longint'(v)) : longint'(v);
        lim = 1;
        for (int d = 0; d < digits; d++) lim = lim * 10;
        ov  = (mag >= lim);
        mag = mag % lim;
        bcd = '0;
        for (int d = 0; d < digits; d++) begin
            bcd[4*d +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
`ifdef BIN2BCD_LZB_EN
        for (int d = digits - 1; d >= 1; d--) begin
            if (bcd[4*d +: 4] != 4'd0) break;
            bcd[4*d +: 4] = 4'hF;
        end
`endif
    endfunction

    // Transaction-level model: a conversion accepted on an edge delivers its result WIDTH+1 edges later.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                activeM[i] = 1'b0;
                ageM[i]    = 0;
                doneM[i]   = 1'b0;
                bcdM[i]    = '0;
                signM[i]   = 1'b0;
                ovfM[i]    = 1'b0;
            end else begin
                doneM[i] = 1'b0;
                if (activeM[i]) begin
                    ageM[i] = ageM[i] + 1;
                    if (ageM[i] == W + 1) begin
                        bcdM[i]    = pendBcd[i];
                        signM[i]   = pendSign[i];
                        ovfM[i]    = pendOvf[i];
                        doneM[i]   = 1'b1;
                        activeM[i] = 1'b0;
                    end
                end else if (startV[i]) begin
                    activeM[i] = 1'b1;
                    ageM[i]    = 0;
                    refConv(decV[i], DIGITS_P[i], SIGNED_P[i], pendBcd[i], pendSign[i], pendOvf[i]);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs on the falling edge.
    always @(negedge clk) begin
        if (checkEn) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("busy[%0d]", i), 32'(busyV[i]), 32'(activeM[i]));
                checkOutput($sformatf("done[%0d]", i), 32'(doneV[i]), 32'(doneM[i]));
                checkOutput($sformatf("bcd[%0d]", i), 32'(bcdAct[i]), 32'(bcdM[i]));
                checkOutput($sformatf("sign[%0d]", i), 32'(signV[i]), 32'(signM[i]));
                checkOutput($sformatf("ovf[%0d]", i), 32'(ovfV[i]), 32'(ovfM[i]));
            end
        end
    end

    // Drive a one-cycle start pulse from the current falling edge.
    task automatic applyStimulus(input int idx, input logic [15:0] v);
        decV[idx]   = v;
        startV[idx] = 1'b1;
        @(negedge clk);
        startV[idx] = 1'b0;
        decV[idx]   = 16'($urandom);
    endtask

    task automatic waitDone(input int idx, input string name);
        for (int n = 0; n < 40 && !doneV[idx]; n++) @(negedge clk);
        checkOutput({name, " done seen"}, 32'(doneV[idx]), 32'd1);
    endtask

    task automatic expectLit(input int idx, input string name, input logic [19:0] bcd,
                             input bit sgn, input bit ov);
        checkOutput({name, " model bcd"}, 32'(bcdM[idx]), 32'(bcd));
        checkOutput({name, " dut bcd"}, 32'(bcdAct[idx]), 32'(bcd));
        checkOutput({name, " model sign"}, 32'(signM[idx]), 32'(sgn));
        checkOutput({name, " dut sign"}, 32'(signV[idx]), 32'(sgn));
        checkOutput({name, " model ovf"}, 32'(ovfM[idx]), 32'(ov));
        checkOutput({name, " dut ovf"}, 32'(ovfV[idx]), 32'(ov));
    endtask

    function automatic logic [15:0] pickValue();
        logic [15:0] corners [7];
        corners = '{16'h0000, 16'h8000, 16'hFFFF, 16'h7FFF, 16'd9999, 16'd10000, 16'd99999 % 65536};
        if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 6)];
        return 16'($urandom);
    endfunction

    initial begin
        int nDone;
        int sawDone;
        for (int i = 0; i < 3; i++) decV[i] = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkEn = 1'b1;
        checkOutput("reset busy", 32'(busyV), 32'd0);
        checkOutput("reset done", 32'(doneV), 32'd0);
        checkOutput("reset bcdA", 32'(bcdA), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(0, 16'h04D2); waitDone(0, "1234");  expectLit(0, "1234", `LZ(20'h01234, 20'hF1234), 1'b0, 1'b0);
        applyStimulus(0, 16'hFDF7); waitDone(0, "-521");  expectLit(0, "-521", `LZ(20'h00521, 20'hFF521), 1'b1, 1'b0);
        applyStimulus(0, 16'h8000); waitDone(0, "8000");  expectLit(0, "8000", 20'h32768, 1'b1, 1'b0);
        applyStimulus(0, 16'hFFFF); waitDone(0, "-1");    expectLit(0, "-1", `LZ(20'h00001, 20'hFFFF1), 1'b1, 1'b0);
        applyStimulus(0, 16'h0000); waitDone(0, "zeroA"); expectLit(0, "zeroA", `LZ(20'h00000, 20'hFFFF0), 1'b0, 1'b0);

        // Start held high through busy must give exactly one result.
        decV[1]   = 16'hFFFF;
        startV[1] = 1'b1;
        nDone     = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (n == 10) startV[1] = 1'b0;
            if (doneV[1]) nDone++;
        end
        checkOutput("held start done count", 32'(nDone), 32'd1);
        expectLit(1, "65535", 20'h65535, 1'b0, 1'b0);
        applyStimulus(1, 16'h0000); waitDone(1, "zeroB"); expectLit(1, "zeroB", `LZ(20'h00000, 20'hFFFF0), 1'b0, 1'b0);

        applyStimulus(2, 16'd12345); waitDone(2, "12345"); expectLit(2, "12345", 20'h02345, 1'b0, 1'b1);
        applyStimulus(2, 16'd999);   waitDone(2, "999");   expectLit(2, "999", `LZ(20'h00999, 20'h0F999), 1'b0, 1'b0);

        // Abort a conversion with reset, then restart and chain a start in the done cycle.
        applyStimulus(0, 16'd1234);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sawDone = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (doneV[0]) sawDone++;
        end
        checkOutput("no done after abort", 32'(sawDone), 32'd0);
        expectLit(0, "after abort", 20'h00000, 1'b0, 1'b0);
        applyStimulus(0, 16'd42); waitDone(0, "42"); expectLit(0, "42", `LZ(20'h00042, 20'hFFF42), 1'b0, 1'b0);
        applyStimulus(0, 16'd7);  waitDone(0, "7 back-to-back"); expectLit(0, "7", `LZ(20'h00007, 20'hFFFF7), 1'b0, 1'b0);

        // Random traffic on all three instances, with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 3; i++) begin
                startV[i] = ($urandom_range(0, 3) == 0);
                decV[i]   = pickValue();
            end
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        startV = '0;
        rst    = 1'b0;
        repeat (25) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
